// File: rtl/cpu_prog_loader_if.sv
// Byte-stream handshake into the program loader.
// A byte moves on a rising clk edge when valid and ready are both high; data is held while valid waits.
interface cpu_prog_loader_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/cpu_prog_loader.sv
// Framed byte-stream loader: fills cpu instruction/data memories word by word
// and opens a counted or open-ended cpu_enable window.
module cpu_prog_loader #(
  parameter int ADDR_STEP = 4,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    srst,
  cpu_prog_loader_if.slave        stream,
  output logic [31:0]             imem_addr,
  output logic                    imem_wen,
  output logic [31:0]             imem_wdata,
  output logic [31:0]             dmem_addr,
  output logic                    dmem_wen,
  output logic [31:0]             dmem_wdata,
  output logic                    cpu_enable,
  output logic                    busy,
  output logic                    run_done,
  output logic                    err,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    IDLE, HDR_ADDR, HDR_CNT, DATA, WRITE, RUN_HDR, RUN
  } state_t;

  localparam logic [7:0] CMD_LOAD_I = 8'h01;
  localparam logic [7:0] CMD_LOAD_D = 8'h02;
  localparam logic [7:0] CMD_RUN    = 8'h03;
  localparam logic [7:0] CMD_HALT   = 8'h04;

  state_t           state_q, state_d;
  logic [31:0]      sr;
  logic [1:0]       bcnt;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_d;
  logic [31:0]      run_cnt;
  logic             xfer;
  logic [31:0]      full32;
  logic [15:0]      full16;

  assign xfer   = stream.valid & stream.ready;
  // Little-endian fields shift in from the top; the last byte completes the value.
  assign full32 = {stream.data, sr[31:8]};
  assign full16 = {stream.data, sr[31:24]};

  assign stream.ready = (state_q != WRITE);
  assign imem_wen     = (state_q == WRITE) && !is_d;
  assign dmem_wen     = (state_q == WRITE) && is_d;
  assign cpu_enable   = (state_q == RUN);
  assign busy         = (state_q != IDLE);
  assign state_dbg    = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (stream.data == CMD_LOAD_I || stream.data == CMD_LOAD_D) state_d = HDR_ADDR;
          else if (stream.data == CMD_RUN)                            state_d = RUN_HDR;
        end
      end
      HDR_ADDR: if (xfer && bcnt == 2'd3) state_d = HDR_CNT;
      HDR_CNT:  if (xfer && bcnt == 2'd1) state_d = (full16 == 16'd0) ? IDLE : DATA;
      DATA:     if (xfer && bcnt == 2'd3) state_d = WRITE;
      WRITE:    state_d = (cnt_q == CNT_W'(1)) ? IDLE : DATA;
      RUN_HDR:  if (xfer && bcnt == 2'd3) state_d = RUN;
      // A zero count never reaches 1, so an open-ended run only ends on HALT.
      RUN: begin
        if ((xfer && stream.data == CMD_HALT) || run_cnt == 32'd1) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= IDLE;
      sr         <= '0;
      bcnt       <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      is_d       <= 1'b0;
      run_cnt    <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      run_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_done <= 1'b0;
      if (xfer) sr <= full32;
      if (state_d != state_q) bcnt <= '0;
      else if (xfer)          bcnt <= bcnt + 2'd1;

      case (state_q)
        IDLE: begin
          if (xfer) begin
            if (stream.data == CMD_LOAD_I || stream.data == CMD_LOAD_D)
              is_d <= (stream.data == CMD_LOAD_D);
            else if (stream.data != CMD_RUN && stream.data != CMD_HALT)
              err <= 1'b1;
          end
        end
        HDR_ADDR: if (xfer && bcnt == 2'd3) addr_q <= full32;
        HDR_CNT:  if (xfer && bcnt == 2'd1) cnt_q <= CNT_W'(full16);
        // Buses load on the last data byte so they are stable during the wen cycle.
        DATA: begin
          if (xfer && bcnt == 2'd3) begin
            if (is_d) begin
              dmem_addr  <= addr_q;
              dmem_wdata <= full32;
            end else begin
              imem_addr  <= addr_q;
              imem_wdata <= full32;
            end
          end
        end
        WRITE: begin
          addr_q <= addr_q + 32'(ADDR_STEP);
          cnt_q  <= cnt_q - CNT_W'(1);
        end
        RUN_HDR: if (xfer && bcnt == 2'd3) run_cnt <= full32;
        RUN: begin
          if (run_cnt != 32'd0) run_cnt <= run_cnt - 32'd1;
          if (xfer && stream.data != CMD_HALT) err <= 1'b1;
          if (state_d == IDLE) run_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cpu_prog_loader.md
Name: cpu_prog_loader

Overview:
- Byte-stream front end that sits directly upstream of the pipelined cpu.
- Receives a framed command stream, from a UART RX or a testbench, over a valid/ready byte handshake.
- Assembles 32-bit words and drives them onto the cpu external write ports of the instruction memory and data memory.
- Drives the cpu enable input for a counted or open-ended run window, and signals completion.

Parameters:
- ADDR_STEP, 4, address increment applied after each word write.
- CNT_W, 16, width of the frame word-count field, sent as 2 bytes; legal values are 1..16.

Ports:
clk  in  1  clock
srst  in  1  synchronous active-high reset
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts byte (transfer = in_valid & in_ready)
imem_addr  out  32  to cpu addr_ext
imem_wen  out  1  to cpu wen_ext
imem_wdata  out  32  to cpu wdata_ext
dmem_addr  out  32  to cpu addr_ext_2
dmem_wen  out  1  to cpu wen_ext_2
dmem_wdata  out  32  to cpu wdata_ext_2
cpu_enable  out  1  to cpu enable
busy  out  1  state != IDLE
run_done  out  1  one-cycle pulse at end of run window
err  out  1  sticky protocol error

Behaviour:
- Reset and clocking: one clock, clk; srst is synchronous and active-high.
- Reset values: all outputs 0 except in_ready, which is 1 in the first cycle after reset. State = IDLE; partial word, address and counters are cleared.
- Reset mid-frame: the partial word is discarded and no write is issued. Reset during RUN drops cpu_enable the next cycle with no run_done pulse.
- Frame formats. All multi-byte fields are little-endian.
  - 0x01 LOAD_I and 0x02 LOAD_D: cmd, addr[4 bytes], count[2 bytes], then count words × 4 bytes.
  - 0x03 RUN: cmd, cycles[4 bytes].
  - 0x04 HALT: cmd.
- States: IDLE, HDR_ADDR, HDR_CNT, DATA, WRITE, RUN_HDR, RUN.
- IDLE:
  - 0x01/0x02: latch target memory, go to HDR_ADDR, and force cpu_enable = 0 in the next cycle.
  - 0x03: go to RUN_HDR.
  - 0x04: no effect.
  - Any other byte: set err and stay in IDLE.
- HDR_ADDR: accept 4 bytes, then go to HDR_CNT.
- HDR_CNT: accept 2 bytes. If count = 0, return to IDLE with no writes; otherwise go to DATA.
- DATA: accept 4 bytes, first byte = wdata[7:0]. When the 4th byte is accepted at cycle t, go to WRITE.
- WRITE, cycle t+1:
  - Selected wen = 1 for exactly 1 cycle, with addr and wdata valid in that same cycle.
  - The non-selected memory's wen stays 0.
  - in_ready = 0.
  - Address += ADDR_STEP (wraps modulo 2^32) and remaining count -= 1.
  - Next state is DATA if the remaining count is nonzero, else IDLE, where in_ready returns at t+2.
- in_ready: 1 in IDLE, HDR_*, DATA, RUN_HDR and RUN; 0 only in WRITE.
- addr/wdata buses: hold their last value while wen = 0.
- RUN_HDR: accept 4 cycle bytes. With cycles = C, cpu_enable = 1 starting the cycle after the last byte is accepted.
  - C > 0: cpu_enable = 1 for exactly C cycles.
  - C = 0: cpu_enable = 1 until HALT.
  - The 32-bit down-counter stops at 0.
- RUN:
  - A HALT byte accepted at cycle t gives cpu_enable = 0 at t+1.
  - Any non-HALT byte is accepted and dropped, sets err, and the run continues.
- End of RUN, by expiry or HALT: run_done = 1 for exactly 1 cycle, in the first cycle with cpu_enable = 0. The state then returns to IDLE.
- Expiry and HALT in the same cycle: a single run_done pulse.
- err: sticky until srst and never alters data flow.
- in_valid low mid-frame: the loader waits indefinitely; there is no timeout.

Test Plan:
- LOAD_I, addr 0x00000010, count 2, words 0xDEADBEEF and 0x12345678:
  - imem_wen pulses twice, at addr 0x10 then 0x14, with matching wdata.
  - dmem_wen stays 0.
  - in_ready is 0 in each WRITE cycle.
- LOAD_D with count 0: no wen pulses, busy falls after the count bytes, and the next frame is accepted.
- RUN, cycles 5: cpu_enable is high for exactly 5 cycles, run_done pulses once in the 6th cycle, and busy returns to 0.
- RUN with cycles 0, then HALT after 20 cycles: cpu_enable drops the cycle after HALT is accepted and run_done pulses once.
- Byte 0x7F in IDLE, and 0x55 during RUN: err goes to 1 and stays there; the run is unaffected.
- srst asserted after the 2nd data byte of a LOAD_I frame:
  - No imem_wen.
  - Outputs are 0 and in_ready is 1 after reset.
  - A following LOAD_I of 1 word at addr 0 writes correctly.
